pixel_packer: RTL and testbench
===============================

# pixel_packer

Packs a single-pixel AXI-Stream into wide multi-pixel bursts, the inverse of the per-pixel sequentializer. It sits after the per-pixel processing path (crop/ROI) and rebuilds PIXELS_PER_BURST-wide beats for the wide DMA/host-facing stream. Partial bursts are flushed at end of line with a lane-valid mask. Line-length and framing errors are reported on sticky flags.

## Interface
- PIXEL_BIT_WIDTH, 16, bits per pixel
- PIXELS_PER_BURST, 16, pixels per output beat; must be ≥2
- USER_WIDTH, 4, tuser width; bits [0]=SOF, [1]=SOL, [2]=EOL, [3]=EOF; any higher bits are passed from the first pixel of the beat
- LINE_PIXELS, 48, expected pixels per line (between SOL and EOL inclusive)
- LANE_BITWIDTH, 4, width of lane counter, ≥ clog2(PIXELS_PER_BURST)
- COL_BITWIDTH, 10, width of per-line pixel counter

- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  PIXEL_BIT_WIDTH  one pixel
- s_axis_tuser  in  USER_WIDTH  per-pixel markers
- m_axis_tvalid  out  1  output burst valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  packed pixels, lane 0 in LSBs
- m_axis_tkeep  out  PIXELS_PER_BURST  lane-valid mask, bit i = lane i holds a real pixel
- m_axis_tuser  out  USER_WIDTH  merged markers of the beat
- line_len_err  out  1  sticky: EOL seen with pixel count ≠ LINE_PIXELS
- frame_err  out  1  sticky: SOF arrived while a partial burst was pending

## Operation
- Accept: a pixel is accepted when s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational). No stall is permitted while the output register is empty.
- Storage: accumulator (data, keep, lane_cnt, held SOF/SOL/upper user bits) and output register.
- Each accepted pixel writes lane lane_cnt, sets keep[lane_cnt], and increments lane_cnt.
- Completion: the accepted pixel completes a burst if lane_cnt == PIXELS_PER_BURST-1 or tuser[EOL]=1.
- On completion, accumulator + current pixel load into the output register in the same cycle.
  - m_axis_tvalid is set.
  - Unused lanes carry zero data with keep=0.
  - Accumulator is cleared, lane_cnt set to 0.
- Output tuser merge:
  - SOF and SOL come from the first pixel of the beat.
  - EOL and EOF come from the completing pixel.
  - Upper bits come from the first pixel.
- Output register holds stable until m_axis_tready; it clears m_axis_tvalid on handshake unless a new burst loads in the same cycle.
- Simultaneous drain and load: the new burst replaces the old one, and m_axis_tvalid stays 1.
- SOF with lane_cnt ≠ 0:
  - The pending partial burst is discarded.
  - The pixel is written to lane 0 (lane_cnt becomes 1).
  - frame_err is set.
- Column counter:
  - Reset to 1 on SOL; incremented on every other accepted pixel.
  - On EOL, the final count (including the EOL pixel) is compared with LINE_PIXELS; any mismatch sets line_len_err.
  - The counter saturates at its maximum.
- EOF without EOL is treated as completion; the burst is emitted with whatever keep is accumulated.
- Error flags clear only on srst.

## Timing
- Reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, line_len_err=0, frame_err=0, lane_cnt=0, column counter=0. s_axis_tready=1 after reset.
- A reset mid-burst drops both the accumulator and the output register with no flush.
- Latency: m_axis_tvalid rises 1 cycle after the completing pixel's handshake.
- Throughput: 1 pixel per cycle sustained when m_axis_tready=1. Output bursts reach 1 per PIXELS_PER_BURST cycles.
- Backpressure: input stalls only while m_axis_tvalid=1 and m_axis_tready=0. No pixel is lost or duplicated.
- Error flags assert 1 cycle after the offending handshake.

## Test plan
- Full line, P=16, LINE_PIXELS=48, pixels 0..47 with SOL on 0 and EOL on 47, tready=1 → 3 beats.
  - Beat 0 lane i = i.
  - All beats have keep=16'hFFFF.
  - Beat 0 tuser=SOL, beat 2 tuser=EOL.
  - No errors.
- Partial flush: 20-pixel line with LINE_PIXELS=20 → beat 1 has lanes 0..3 = 16..19, keep=16'h000F, lanes 4..15 = 0, EOL set. No error.
- Backpressure: m_axis_tready=0 for 30 cycles after the first beat completes → s_axis_tready=0 from the cycle m_axis_tvalid rises. m_axis_tdata is stable. After release, all 48 pixels arrive in order.
- Line length: EOL on the 47th pixel with LINE_PIXELS=48 → line_len_err=1 one cycle later and stays 1 until srst.
- Frame error: SOF after 5 pixels of a burst → the 5 pixels are dropped and frame_err=1. The next beat has the SOF pixel in lane 0 with tuser SOF set.
- Reset mid-burst: srst after 7 pixels → all outputs return to reset values. The next 16 pixels form one clean beat, keep=16'hFFFF.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs a one-pixel-per-beat AXI-Stream into PIXELS_PER_BURST-wide beats, flushing
// partial bursts with a lane mask at end of line and raising sticky framing flags.
module pixel_packer #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int PIXELS_PER_BURST = 16,
  parameter int USER_WIDTH       = 4,
  parameter int LINE_PIXELS      = 48,
  parameter int LANE_BITWIDTH    = 4,
  parameter int COL_BITWIDTH     = 10
) (
  input  logic                                      clk,
  input  logic                                      srst,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]                s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                     s_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
  output logic [PIXELS_PER_BURST-1:0]               m_axis_tkeep,
  output logic [USER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                      line_len_err,
  output logic                                      frame_err
);

  localparam int BEAT_W  = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
  localparam int SOF_BIT = 0;
  localparam int SOL_BIT = 1;
  localparam int EOL_BIT = 2;
  localparam int EOF_BIT = 3;
  localparam logic [LANE_BITWIDTH-1:0] LANE_ZERO = {LANE_BITWIDTH{1'b0}};
  localparam logic [LANE_BITWIDTH-1:0] LANE_ONE  = LANE_BITWIDTH'(1);
  localparam logic [LANE_BITWIDTH-1:0] LAST_LANE = LANE_BITWIDTH'(PIXELS_PER_BURST - 1);
  localparam logic [COL_BITWIDTH-1:0]  COL_ZERO  = {COL_BITWIDTH{1'b0}};
  localparam logic [COL_BITWIDTH-1:0]  COL_ONE   = COL_BITWIDTH'(1);
  localparam logic [COL_BITWIDTH-1:0]  COL_MAX   = {COL_BITWIDTH{1'b1}};
  localparam logic [COL_BITWIDTH-1:0]  LINE_LEN  = COL_BITWIDTH'(LINE_PIXELS);

  logic [BEAT_W-1:0]           acc_data_r;
  logic [PIXELS_PER_BURST-1:0] acc_keep_r;
  logic [LANE_BITWIDTH-1:0]    lane_cnt_r;
  logic [USER_WIDTH-1:0]       acc_user_r;
  logic [COL_BITWIDTH-1:0]     col_cnt_r;

  logic                        accept_s;
  logic                        restart_s;
  logic                        first_s;
  logic                        complete_s;
  logic [LANE_BITWIDTH-1:0]    eff_lane_s;
  logic [BEAT_W-1:0]           base_data_s;
  logic [PIXELS_PER_BURST-1:0] base_keep_s;
  logic [BEAT_W-1:0]           next_data_s;
  logic [PIXELS_PER_BURST-1:0] next_keep_s;
  logic [USER_WIDTH-1:0]       first_user_s;
  logic [USER_WIDTH-1:0]       merged_user_s;
  logic [COL_BITWIDTH-1:0]     col_next_s;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;

  // Lane placement, burst completion, marker merge and next column count.
  always_comb begin
    accept_s  = s_axis_tvalid && s_axis_tready;
    // A SOF landing mid-burst throws away the partial burst and restarts at lane 0.
    restart_s = accept_s && s_axis_tuser[SOF_BIT] && (lane_cnt_r != LANE_ZERO);
    if (restart_s) begin
      eff_lane_s  = LANE_ZERO;
      base_data_s = {BEAT_W{1'b0}};
      base_keep_s = {PIXELS_PER_BURST{1'b0}};
    end else begin
      eff_lane_s  = lane_cnt_r;
      base_data_s = acc_data_r;
      base_keep_s = acc_keep_r;
    end
    next_data_s = base_data_s;
    next_keep_s = base_keep_s;
    for (int i = 0; i < PIXELS_PER_BURST; i++) begin
      if (eff_lane_s == LANE_BITWIDTH'(i)) begin
        next_data_s[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
        next_keep_s[i] = 1'b1;
      end else begin
        next_data_s[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = base_data_s[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
        next_keep_s[i] = base_keep_s[i];
      end
    end
    first_s = (eff_lane_s == LANE_ZERO);
    if (first_s) begin
      first_user_s = s_axis_tuser;
    end else begin
      first_user_s = acc_user_r;
    end
    merged_user_s          = first_user_s;
    merged_user_s[EOL_BIT] = s_axis_tuser[EOL_BIT];
    merged_user_s[EOF_BIT] = s_axis_tuser[EOF_BIT];
    complete_s = accept_s && ((eff_lane_s == LAST_LANE) ||
                              s_axis_tuser[EOL_BIT] || s_axis_tuser[EOF_BIT]);
    if (s_axis_tuser[SOL_BIT]) begin
      col_next_s = COL_ONE;
    end else if (col_cnt_r == COL_MAX) begin
      col_next_s = col_cnt_r;
    end else begin
      col_next_s = col_cnt_r + COL_ONE;
    end
  end

  // Accumulator: collects pixels of the burst under construction.
  always_ff @(posedge clk) begin
    if (srst || complete_s) begin
      acc_data_r <= {BEAT_W{1'b0}};
      acc_keep_r <= {PIXELS_PER_BURST{1'b0}};
      lane_cnt_r <= LANE_ZERO;
      acc_user_r <= {USER_WIDTH{1'b0}};
    end else if (accept_s) begin
      acc_data_r <= next_data_s;
      acc_keep_r <= next_keep_s;
      lane_cnt_r <= eff_lane_s + LANE_ONE;
      acc_user_r <= first_user_s;
    end
  end

  // Output register: loads a finished burst, holds it until the downstream handshake.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {BEAT_W{1'b0}};
      m_axis_tkeep  <= {PIXELS_PER_BURST{1'b0}};
      m_axis_tuser  <= {USER_WIDTH{1'b0}};
    end else if (complete_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= next_data_s;
      m_axis_tkeep  <= next_keep_s;
      m_axis_tuser  <= merged_user_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Column counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      col_cnt_r    <= COL_ZERO;
      line_len_err <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (accept_s) begin
        col_cnt_r <= col_next_s;
      end
      if (accept_s && s_axis_tuser[EOL_BIT] && (col_next_s != LINE_LEN)) begin
        line_len_err <= 1'b1;
      end
      if (restart_s) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Randomized bench for pixel_packer: a queue-based model of burst formation,
// marker merge, line length and framing rules predicts every output beat and flag.
module tb_pixel_packer;

  localparam int W  = 16;
  localparam int P  = 16;
  localparam int U  = 4;
  localparam int LP = 48;
  localparam int BW = W * P;

  logic          clk = 1'b0;
  logic          srst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic [U-1:0]  s_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [BW-1:0] m_axis_tdata;
  logic [P-1:0]  m_axis_tkeep;
  logic [U-1:0]  m_axis_tuser;
  logic          line_len_err;
  logic          frame_err;

  pixel_packer #(
    .PIXEL_BIT_WIDTH(W), .PIXELS_PER_BURST(P), .USER_WIDTH(U),
    .LINE_PIXELS(LP), .LANE_BITWIDTH(4), .COL_BITWIDTH(10)
  ) dut (
    .clk(clk), .srst(srst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .line_len_err(line_len_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus queue
  logic [W-1:0] in_data_q[$];
  logic [U-1:0] in_user_q[$];
  bit drv_valid = 1'b0;
  int vprob = 100;
  int rprob = 100;
  bit bp_arm = 1'b0;
  int bp_cnt = 0;
  bit prev_stall = 1'b0;
  logic [BW-1:0] prev_data;

  // reference model state
  logic [W-1:0]  cur_data[$];
  logic [U-1:0]  cur_user[$];
  int            col = 0;
  bit            exp_lle = 1'b0;
  bit            exp_fe = 1'b0;
  logic [BW-1:0] exp_data_q[$];
  logic [P-1:0]  exp_keep_q[$];
  logic [U-1:0]  exp_user_q[$];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_pixel(input logic [W-1:0] d, input logic [U-1:0] u);
    in_data_q.push_back(d);
    in_user_q.push_back(u);
  endtask

  // n pixels; first pixel carries first_u, last carries EOL when eol is set
  task automatic push_line(input int n, input logic [U-1:0] first_u, input bit eol, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [U-1:0] u;
      logic [W-1:0] d;
      u = 4'b0000;
      if (i == 0) u = u | first_u;
      if (i == n - 1 && eol) u = u | 4'b0100;
      d = rnd ? W'($urandom) : W'(i);
      push_pixel(d, u);
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic [U-1:0] u);
    logic [BW-1:0] bd;
    logic [P-1:0]  bk;
    logic [U-1:0]  bu;
    if (u[0] && cur_data.size() != 0) begin
      exp_fe = 1'b1;
      cur_data.delete();
      cur_user.delete();
    end
    cur_data.push_back(d);
    cur_user.push_back(u);
    if (u[1]) col = 1;
    else if (col < 1023) col = col + 1;
    if (u[2] && col != LP) exp_lle = 1'b1;
    if (cur_data.size() == P || u[2] || u[3]) begin
      bd = '0;
      bk = '0;
      for (int i = 0; i < cur_data.size(); i++) begin
        bd[i*W +: W] = cur_data[i];
        bk[i] = 1'b1;
      end
      bu = cur_user[0];
      bu[2] = u[2];
      bu[3] = u[3];
      exp_data_q.push_back(bd);
      exp_keep_q.push_back(bk);
      exp_user_q.push_back(bu);
      cur_data.delete();
      cur_user.delete();
    end
  endtask

  // one clock: drive at negedge, check just after, advance to next negedge
  task automatic cycle();
    if (bp_arm && exp_data_q.size() != 0) begin
      bp_cnt = 30;
      bp_arm = 1'b0;
    end
    m_axis_tready = (bp_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < rprob);
    if (bp_cnt > 0) bp_cnt--;
    if (!drv_valid && in_data_q.size() != 0 && $urandom_range(0, 99) < vprob) drv_valid = 1'b1;
    s_axis_tvalid = drv_valid;
    s_axis_tdata  = drv_valid ? in_data_q[0] : '0;
    s_axis_tuser  = drv_valid ? in_user_q[0] : '0;
    #1;
    check("m_tvalid", BW'(m_axis_tvalid), BW'(exp_data_q.size() != 0));
    check("s_tready", BW'(s_axis_tready), BW'(!m_axis_tvalid || m_axis_tready));
    check("line_len_err", BW'(line_len_err), BW'(exp_lle));
    check("frame_err", BW'(frame_err), BW'(exp_fe));
    if (prev_stall) check("hold_data", m_axis_tdata, prev_data);
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready && exp_data_q.size() != 0) begin
      check("beat_data", m_axis_tdata, exp_data_q.pop_front());
      check("beat_keep", BW'(m_axis_tkeep), BW'(exp_keep_q.pop_front()));
      check("beat_user", BW'(m_axis_tuser), BW'(exp_user_q.pop_front()));
    end
    if (s_axis_tvalid && s_axis_tready) begin
      model_accept(in_data_q.pop_front(), in_user_q.pop_front());
      drv_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input int limit);
    int c;
    c = 0;
    while ((in_data_q.size() != 0 || exp_data_q.size() != 0) && c < limit) begin
      cycle();
      c++;
    end
    check("drain_in_time", BW'(c < limit), BW'(1));
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    m_axis_tready = 1'b0;
    drv_valid = 1'b0;
    prev_stall = 1'b0;
    bp_arm = 1'b0;
    bp_cnt = 0;
    in_data_q.delete(); in_user_q.delete();
    cur_data.delete(); cur_user.delete();
    exp_data_q.delete(); exp_keep_q.delete(); exp_user_q.delete();
    col = 0; exp_lle = 1'b0; exp_fe = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", BW'(m_axis_tvalid), BW'(0));
    check("rst_tdata", m_axis_tdata, BW'(0));
    check("rst_tkeep", BW'(m_axis_tkeep), BW'(0));
    check("rst_tuser", BW'(m_axis_tuser), BW'(0));
    check("rst_lle", BW'(line_len_err), BW'(0));
    check("rst_fe", BW'(frame_err), BW'(0));
    check("rst_tready", BW'(s_axis_tready), BW'(1));
    srst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    srst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    do_reset();

    // full 48-pixel line, SOL first, EOL last, no stalls
    vprob = 100; rprob = 100;
    push_line(48, 4'b0010, 1'b1, 1'b0);
    run_idle(200);

    // 20-pixel line: partial flush with keep 000F (length mismatch against 48)
    push_line(20, 4'b0010, 1'b1, 1'b0);
    run_idle(200);
    do_reset();

    // backpressure for 30 cycles once the first beat is up
    bp_arm = 1'b1;
    push_line(48, 4'b0011, 1'b1, 1'b1);
    run_idle(400);

    // short line of 47 pixels
    push_line(47, 4'b0010, 1'b1, 1'b1);
    run_idle(200);
    repeat (5) cycle();
    do_reset();

    // SOF after 5 pixels of a burst
    push_line(5, 4'b0010, 1'b0, 1'b1);
    push_line(16, 4'b0011, 1'b0, 1'b1);
    run_idle(200);
    do_reset();

    // reset mid-burst after 7 pixels, then one clean 16-pixel beat
    push_line(7, 4'b0010, 1'b0, 1'b1);
    run_idle(100);
    do_reset();
    push_line(16, 4'b0000, 1'b0, 1'b1);
    run_idle(100);

    // long line: the column counter must saturate, not wrap back to 48
    do_reset();
    push_line(1024 + LP, 4'b0010, 1'b1, 1'b1);
    run_idle(3000);

    // randomized lines with random flow control and occasional stray markers
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) do_reset();
      vprob = $urandom_range(30, 100);
      rprob = $urandom_range(20, 100);
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < 30; j++) begin
          logic [U-1:0] u;
          u = 4'b0000;
          for (int b = 0; b < U; b++) if ($urandom_range(0, 9) == 0) u[b] = 1'b1;
          push_pixel(W'($urandom), u);
        end
      end else begin
        push_line($urandom_range(1, 60), ($urandom_range(0, 2) == 0) ? 4'b0011 : 4'b0010,
                  $urandom_range(0, 9) != 0, 1'b1);
      end
      run_idle(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
